oled_frame_renderer: RTL and testbench
======================================

// Module: oled_frame_renderer
// PURPOSE
//   Upstream pixel source for the SSD1306 SPI streamer. Renders one 128x64 pong frame
//   (ball, two paddles, dashed centre net) as a stream of 1024 page bytes, byte index =
//   page*128 + column, in horizontal-addressing order. Bit b of a byte is row page*8+b.
//   The streamer pulls bytes over a valid/ready handshake. Object positions are snapshotted
//   once per frame so a frame never tears.
// PARAMETERS
//   BALL_SIZE  2    ball edge length in pixels (square)
//   PAD_W      2    paddle width in pixels
//   PAD_H      12   paddle height in pixels
//   PAD_L_X    2    left paddle leftmost column
//   PAD_R_X    124  right paddle leftmost column
//   NET_X      63   column of the centre net
//   NET_EN     1    1 = draw the net, 0 = omit it
// PORTS
//   clk           in   1  system clock
//   rst           in   1  synchronous active-high reset
//   i_ball_x      in   7  ball top-left column, 0..127
//   i_ball_y      in   6  ball top-left row, 0..63
//   i_pad_l_y     in   6  left paddle top row
//   i_pad_r_y     in   6  right paddle top row
//   o_byte        out  8  current page byte
//   o_byte_valid  out  1  o_byte holds a valid byte
//   i_byte_ready  in   1  consumer accepts o_byte this cycle
//   o_frame_start out  1  high while o_byte is byte index 0
//   o_frame_done  out  1  one-cycle pulse after byte 1023 is accepted
// BEHAVIOUR
// - Reset (priority over everything, any cycle): o_byte=0, o_byte_valid=0, o_frame_start=0,
//   o_frame_done=0, col=0, page=0, shadow regs=0.
// - States:
//   - IDLE: entered only from reset. On the first cycle with rst=0, snapshot all four
//     position inputs into shadow regs. Go to LOAD.
//   - LOAD: one cycle. o_byte <= render(0,0) from the shadow regs, o_byte_valid <= 1,
//     o_frame_start <= 1. Go to STREAM.
//   - STREAM: accept = o_byte_valid & i_byte_ready.
// - Accept at a byte other than 1023:
//   - Advance the index.
//   - Load render(next) into o_byte in the same edge.
//   - o_byte_valid stays 1, so throughput is 1 byte/cycle.
// - Accept at byte 1023 (page 7, col 127):
//   - Index wraps to 0.
//   - Shadow regs re-snapshot the inputs on that edge.
//   - o_byte <= render(0,0) computed from the NEW snapshot.
//   - o_frame_done=1 for exactly one cycle.
//   - o_frame_start=1.
// - o_frame_start=1 exactly while the index is 0 and valid. It falls on the first accept
//   of the frame.
// - No accept (ready low): o_byte, index and flags hold. Inputs are not sampled mid-frame.
// - Render(page p, col c), evaluated for each bit b with row y = 8p+b. The bit is set if
//   ANY of these is true:
//   - ball:   ball_x <= c < ball_x+BALL_SIZE  and  ball_y <= y < ball_y+BALL_SIZE
//   - L pad:  PAD_L_X <= c < PAD_L_X+PAD_W  and  pad_l_y <= y < pad_l_y+PAD_H
//   - R pad:  PAD_R_X <= c < PAD_R_X+PAD_W  and  pad_r_y <= y < pad_r_y+PAD_H
//   - net:    NET_EN and c==NET_X and y[2]==0
// - Bounds are computed 8 bits wide (ball_x+BALL_SIZE up to 129). Objects past col 127 or
//   row 63 are clipped and never wrap to col/row 0.
// - Render is combinational from index+shadow. Output is registered, so there are no
//   combinational paths from i_byte_ready to o_byte or o_byte_valid.
// TESTING
// 1. Reset, then ready=1 for 1024 cycles with ball(10,20), pads 0/40:
//    -> exactly 1024 accepts, one frame_done pulse on the cycle after the last accept,
//       frame_start only on byte 0.
// 2. Ball(10,20):
//    -> bytes 266 and 267 (page 2, cols 10, 11) = 0x30.
//    -> page 2 bytes at cols 9 and 12 = 0x00.
// 3. pad_l_y=0:
//    -> bytes 2 and 3 = 0xFF, bytes 130 and 131 = 0x0F.
//    -> pad_r_y=56: bytes 1020 and 1021 = 0xFF.
// 4. Ball(127,63):
//    -> byte 1023 = 0x80, byte 896 (page 7, col 0) = 0x00, byte 0 unaffected by the ball.
//    -> net: byte 63 = 0x0F on every page (NET_EN=1).
// 5. Change ball_x 10->50 at byte 300 of a frame:
//    -> the rest of that frame still renders x=10; the next frame renders x=50.
// 6. ready toggled randomly, then rst pulsed at byte 500:
//    -> o_byte and index stable while ready=0.
//    -> after rst: valid=0, then byte 0 is re-presented with frame_start=1.

Source files
------------

// File: rtl/oled_frame_renderer.sv
// Pong frame renderer for the SSD1306 streamer: emits 1024 page bytes per frame over valid/ready,
// with object positions snapshotted once per frame so a frame never tears.
module oled_frame_renderer #(
  parameter int BALL_SIZE = 2,
  parameter int PAD_W     = 2,
  parameter int PAD_H     = 12,
  parameter int PAD_L_X   = 2,
  parameter int PAD_R_X   = 124,
  parameter int NET_X     = 63,
  parameter bit NET_EN    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] ball_x_i,
  input  logic [5:0] ball_y_i,
  input  logic [5:0] pad_l_y_i,
  input  logic [5:0] pad_r_y_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       frame_start_o,
  output logic       frame_done_o
);

  // state    | meaning
  // S_IDLE   | just out of reset, snapshot positions
  // S_LOAD   | present byte 0 of the first frame
  // S_STREAM | stream bytes, wrap and re-snapshot after byte 1023
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d, start_q, start_d, done_q, done_d;
  logic [6:0]  sh_bx_q, sh_bx_d;
  logic [5:0]  sh_by_q, sh_by_d, sh_ly_q, sh_ly_d, sh_ry_q, sh_ry_d;

  logic        accept, last, use_inputs;
  logic [9:0]  idx_inc, rend_idx;
  logic [6:0]  rend_bx;
  logic [5:0]  rend_by, rend_ly, rend_ry;
  logic [7:0]  rend_byte;

  // Bounds use 8-bit arithmetic so objects near the right/bottom edge clip instead of wrapping.
  function automatic logic [7:0] render(input logic [9:0] idx, input logic [6:0] bx,
                                        input logic [5:0] by, input logic [5:0] ly,
                                        input logic [5:0] ry);
    logic [7:0] c, y, bx8, by8, ly8, ry8, r;
    logic       ball, padl, padr, net;
    c   = {1'b0, idx[6:0]};
    bx8 = {1'b0, bx};
    by8 = {2'b00, by};
    ly8 = {2'b00, ly};
    ry8 = {2'b00, ry};
    r   = '0;
    for (int b = 0; b < 8; b++) begin
      y    = {2'b00, idx[9:7], 3'(b)};
      ball = (c >= bx8) && (c < bx8 + 8'(BALL_SIZE)) && (y >= by8) && (y < by8 + 8'(BALL_SIZE));
      padl = (c >= 8'(PAD_L_X)) && (c < 8'(PAD_L_X + PAD_W)) && (y >= ly8) && (y < ly8 + 8'(PAD_H));
      padr = (c >= 8'(PAD_R_X)) && (c < 8'(PAD_R_X + PAD_W)) && (y >= ry8) && (y < ry8 + 8'(PAD_H));
      net  = NET_EN && (c == 8'(NET_X)) && !y[2];
      r[b] = ball | padl | padr | net;
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: state_d = S_STREAM;
      default:  state_d = S_IDLE;
    endcase
  end

  assign accept     = valid_q & byte_ready_i;
  assign last       = (idx_q == 10'd1023);
  assign idx_inc    = idx_q + 10'd1;
  // On the final accept the next frame's byte 0 must come from the fresh snapshot.
  assign use_inputs = (state_q == S_STREAM) && last;
  assign rend_idx   = (state_q == S_STREAM) ? idx_inc : 10'd0;
  assign rend_bx    = use_inputs ? ball_x_i  : sh_bx_q;
  assign rend_by    = use_inputs ? ball_y_i  : sh_by_q;
  assign rend_ly    = use_inputs ? pad_l_y_i : sh_ly_q;
  assign rend_ry    = use_inputs ? pad_r_y_i : sh_ry_q;
  assign rend_byte  = render(rend_idx, rend_bx, rend_by, rend_ly, rend_ry);

  always_comb begin
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    start_d = start_q;
    done_d  = 1'b0;
    sh_bx_d = sh_bx_q;
    sh_by_d = sh_by_q;
    sh_ly_d = sh_ly_q;
    sh_ry_d = sh_ry_q;
    case (state_q)
      S_IDLE: begin
        sh_bx_d = ball_x_i;
        sh_by_d = ball_y_i;
        sh_ly_d = pad_l_y_i;
        sh_ry_d = pad_r_y_i;
      end
      S_LOAD: begin
        idx_d   = 10'd0;
        byte_d  = rend_byte;
        valid_d = 1'b1;
        start_d = 1'b1;
      end
      S_STREAM: begin
        if (accept) begin
          idx_d  = idx_inc;
          byte_d = rend_byte;
          if (last) begin
            sh_bx_d = ball_x_i;
            sh_by_d = ball_y_i;
            sh_ly_d = pad_l_y_i;
            sh_ry_d = pad_r_y_i;
            done_d  = 1'b1;
            start_d = 1'b1;
          end else begin
            start_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      sh_bx_q <= '0;
      sh_by_q <= '0;
      sh_ly_q <= '0;
      sh_ry_q <= '0;
    end else begin
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      start_q <= start_d;
      done_q  <= done_d;
      sh_bx_q <= sh_bx_d;
      sh_by_q <= sh_by_d;
      sh_ly_q <= sh_ly_d;
      sh_ry_q <= sh_ry_d;
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = valid_q;
  assign frame_start_o = start_q;
  assign frame_done_o  = done_q;

endmodule

// File: tb/tb_oled_frame_renderer.sv
// Bench for oled_frame_renderer: paints each frame into a 64x128 bitmap and compares every
// streamed byte, plus spot checks of edge/clipping cases, random backpressure and mid-frame reset.
module tb_oled_frame_renderer;
  logic       clk = 1'b0;
  logic       rst_i;
  logic [6:0] ball_x_i;
  logic [5:0] ball_y_i, pad_l_y_i, pad_r_y_i;
  logic [7:0] byte_o;
  logic       byte_valid_o, byte_ready_i, frame_start_o, frame_done_o;

  always #5 clk = ~clk;

  oled_frame_renderer dut (
    .clk_i(clk), .rst_i(rst_i),
    .ball_x_i(ball_x_i), .ball_y_i(ball_y_i), .pad_l_y_i(pad_l_y_i), .pad_r_y_i(pad_r_y_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
    .frame_start_o(frame_start_o), .frame_done_o(frame_done_o)
  );

  int         n_vec = 0, n_err = 0;
  bit         bm [0:63][0:127];
  logic [7:0] exp_mem [0:1023];
  logic [7:0] cap [0:1023];
  int         m_idx = 0, m_wait = 0, m_frames = 0, n_acc = 0, n_done_seen = 0;
  bit         m_valid = 0, m_done = 0, prev_hold = 0;
  logic [7:0] prev_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic paint(input int x0, input int y0, input int w, input int h);
    for (int x = x0; x < x0 + w; x++)
      for (int y = y0; y < y0 + h; y++)
        if (x < 128 && y < 64) bm[y][x] = 1'b1;
  endtask

  // Reference frame: ball 2x2, paddles 2x12 at cols 2 and 124, dashed net at col 63.
  task automatic build(input int bx, input int by, input int ly, input int ry);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 128; x++) bm[y][x] = 1'b0;
    paint(bx, by, 2, 2);
    paint(2, ly, 2, 12);
    paint(124, ry, 2, 12);
    for (int y = 0; y < 64; y++) if ((y % 8) < 4) bm[y][63] = 1'b1;
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 128; c++)
        for (int b = 0; b < 8; b++) exp_mem[p*128 + c][b] = bm[p*8 + b][c];
  endtask

  // Called at a negedge: check outputs, drive ready, advance model across one posedge.
  task automatic step(input bit r);
    chk("valid", {31'b0, byte_valid_o}, {31'b0, m_valid});
    if (m_valid) begin
      chk($sformatf("byte[%0d]", m_idx), {24'b0, byte_o}, {24'b0, exp_mem[m_idx]});
      chk($sformatf("start[%0d]", m_idx), {31'b0, frame_start_o}, {31'b0, m_idx == 0});
      if (prev_hold) chk("hold", {24'b0, byte_o}, {24'b0, prev_byte});
      cap[m_idx] = byte_o;
    end
    chk("done", {31'b0, frame_done_o}, {31'b0, m_done});
    if (frame_done_o) n_done_seen++;
    prev_byte    = byte_o;
    byte_ready_i = r;
    @(posedge clk);
    prev_hold = m_valid && !r;
    if (m_valid && r) begin
      n_acc++;
      if (m_idx == 1023) begin
        m_idx = 0;
        build(ball_x_i, ball_y_i, pad_l_y_i, pad_r_y_i);
        m_done = 1;
        m_frames++;
      end else begin
        m_idx++;
        m_done = 0;
      end
    end else m_done = 0;
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    byte_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, byte_valid_o}, 32'd0);
    chk("rst_byte", {24'b0, byte_o}, 32'd0);
    chk("rst_start", {31'b0, frame_start_o}, 32'd0);
    chk("rst_done", {31'b0, frame_done_o}, 32'd0);
    rst_i = 1'b0;
    build(ball_x_i, ball_y_i, pad_l_y_i, pad_r_y_i);
    m_idx = 0; m_valid = 0; m_done = 0; m_wait = 2; prev_hold = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 8) begin step(1'b0); n++; end
    chk(tag, {31'b0, m_valid}, 32'd1);
  endtask

  initial begin
    int acc_frame1, start_frames, cyc;
    rst_i = 1'b1; byte_ready_i = 1'b0;
    ball_x_i = 7'd10; ball_y_i = 6'd20; pad_l_y_i = 6'd0; pad_r_y_i = 6'd40;
    @(negedge clk);
    do_reset();
    wait_valid("startup_timeout");

    // Frame 1: full-rate, inputs changed at byte 300 must not affect this frame.
    n_acc = 0; n_done_seen = 0;
    for (int i = 0; i < 1024; i++) begin
      if (m_idx == 300) begin ball_x_i = 7'd50; pad_r_y_i = 6'd56; end
      step(1'b1);
    end
    acc_frame1 = n_acc;
    chk("f1_accepts", acc_frame1, 32'd1024);
    chk("f1_b266", {24'b0, cap[266]}, 32'h30);
    chk("f1_b267", {24'b0, cap[267]}, 32'h30);
    chk("f1_b265", {24'b0, cap[265]}, 32'h00);
    chk("f1_b268", {24'b0, cap[268]}, 32'h00);
    chk("f1_b306_old_x", {24'b0, cap[306]}, 32'h00);
    chk("f1_b2", {24'b0, cap[2]}, 32'hFF);
    chk("f1_b3", {24'b0, cap[3]}, 32'hFF);
    chk("f1_b130", {24'b0, cap[130]}, 32'h0F);
    chk("f1_b131", {24'b0, cap[131]}, 32'h0F);
    for (int p = 0; p < 8; p++) chk($sformatf("f1_net_p%0d", p), {24'b0, cap[p*128 + 63]}, 32'h0F);
    step(1'b1);
    chk("f1_done_pulses", n_done_seen, 32'd1);

    // Frame 2: new snapshot (ball x=50, right paddle at 56); queue the corner ball for frame 3.
    for (int i = 0; i < 1023; i++) begin
      if (m_idx == 600) begin ball_x_i = 7'd127; ball_y_i = 6'd63; end
      step(1'b1);
    end
    chk("f2_b306", {24'b0, cap[306]}, 32'h30);
    chk("f2_b266", {24'b0, cap[266]}, 32'h00);
    chk("f2_b1020", {24'b0, cap[1020]}, 32'hFF);
    chk("f2_b1021", {24'b0, cap[1021]}, 32'hFF);

    // Frame 3: clipped corner ball under random backpressure; randomize next frame's snapshot.
    start_frames = m_frames; cyc = 0;
    while (m_frames == start_frames && cyc < 8000) begin
      if (m_idx == 100) begin
        ball_x_i = 7'($urandom_range(0, 127)); ball_y_i = 6'($urandom_range(0, 63));
        pad_l_y_i = 6'($urandom_range(0, 63)); pad_r_y_i = 6'($urandom_range(0, 63));
      end
      step($urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("f3_timeout", {31'b0, m_frames != start_frames}, 32'd1);
    chk("f3_b1023", {24'b0, cap[1023]}, 32'h80);
    chk("f3_b896", {24'b0, cap[896]}, 32'h00);
    chk("f3_b0", {24'b0, cap[0]}, 32'h00);
    chk("f3_b959_net", {24'b0, cap[959]}, 32'h0F);

    // Frame 4: random ready and churning inputs, then reset in the middle of byte 500.
    cyc = 0;
    while (m_idx != 500 && cyc < 4000) begin
      ball_x_i = 7'($urandom); ball_y_i = 6'($urandom);
      pad_l_y_i = 6'($urandom); pad_r_y_i = 6'($urandom);
      step($urandom_range(0, 1) == 1);
      cyc++;
    end
    chk("f4_reach_500", m_idx, 32'd500);
    do_reset();
    wait_valid("post_rst_timeout");
    chk("post_rst_start", {31'b0, frame_start_o}, 32'd1);
    chk("post_rst_byte0", {24'b0, byte_o}, {24'b0, exp_mem[0]});
    for (int i = 0; i < 300; i++) step($urandom_range(0, 1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
